// File: rtl/snake_body_controller.sv
// Snake body controller: head movement, direction handling, apple growth,
// wall/self collision detection and a registered segment query port.
// The body is a circular buffer of (x,y) entries indexed from a head pointer.
module snake_body_controller #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned HEIGHT  = 32,
  parameter int unsigned STARTX  = 5,
  parameter int unsigned STARTY  = 5,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] dirIn,
  input  logic       dirValid,
  input  logic [6:0] appleX,
  input  logic [6:0] appleY,
  output logic [6:0] headX,
  output logic [6:0] headY,
  output logic [6:0] length,
  input  logic [5:0] qIdx,
  output logic [6:0] qX,
  output logic [6:0] qY,
  output logic       qValid,
  output logic       ate,
  output logic       gameOver
);

  localparam int unsigned CW = 7;
  localparam int unsigned PW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] X_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] X_START = CW'(STARTX);
  localparam logic [CW-1:0] Y_START = CW'(STARTY);
  localparam logic [CW-1:0] LEN_MAX = CW'(MAX_LEN);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    cur_dir;
  logic [1:0]    pend_dir;
  logic [CW-1:0] head_x;
  logic [CW-1:0] head_y;
  logic [CW-1:0] len_q;
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] body_x [MAX_LEN];
  logic [CW-1:0] body_y [MAX_LEN];
  logic          ate_q;
  logic          game_over_q;
  logic [CW-1:0] qx_q;
  logic [CW-1:0] qy_q;
  logic          qv_q;

  logic [1:0]    eff_dir;
  logic [CW-1:0] nx;
  logic [CW-1:0] ny;
  logic          wall;
  logic          eat;
  logic          grow;
  logic          hit;
  logic [PW-1:0] next_ptr;
  logic [CW-1:0] seg_x [MAX_LEN];
  logic [CW-1:0] seg_y [MAX_LEN];

  assign next_ptr = head_ptr + PW'(1);

  // Direction used by a tick: a reversal is only legal for a lone head.
  always_comb begin
    eff_dir = pend_dir;
    if ((pend_dir == (cur_dir ^ 2'b10)) && (len_q != CW'(1))) begin
      eff_dir = cur_dir;
    end
  end

  // Candidate head position and wall test for the effective direction.
  always_comb begin
    nx   = head_x;
    ny   = head_y;
    wall = 1'b0;
    case (eff_dir)
      DIR_UP: begin
        wall = (head_y == '0);
        ny   = head_y - CW'(1);
      end
      DIR_RIGHT: begin
        wall = (head_x == X_LAST);
        nx   = head_x + CW'(1);
      end
      DIR_DOWN: begin
        wall = (head_y == Y_LAST);
        ny   = head_y + CW'(1);
      end
      default: begin
        wall = (head_x == '0);
        nx   = head_x - CW'(1);
      end
    endcase
  end

  assign eat  = (nx == appleX) && (ny == appleY);
  assign grow = eat && (len_q < LEN_MAX);

  // Segments ordered head-first, unrolled from the circular buffer.
  always_comb begin
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      seg_x[i] = body_x[PW'(head_ptr - PW'(i))];
      seg_y[i] = body_y[PW'(head_ptr - PW'(i))];
    end
  end

  // Self-hit against occupied segments; the tail is vacated unless growing.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((CW'(i) < len_q) &&
          !((CW'(i) == (len_q - CW'(1))) && !grow) &&
          (seg_x[i] == nx) && (seg_y[i] == ny)) begin
        hit = 1'b1;
      end
    end
  end

  // Game FSM, movement and body buffer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cur_dir     <= DIR_RIGHT;
      pend_dir    <= DIR_RIGHT;
      head_x      <= X_START;
      head_y      <= Y_START;
      len_q       <= CW'(1);
      head_ptr    <= '0;
      ate_q       <= 1'b0;
      game_over_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= (i == 0) ? X_START : '0;
        body_y[i] <= (i == 0) ? Y_START : '0;
      end
    end else begin
      ate_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dirValid) begin
            cur_dir  <= dirIn;
            pend_dir <= dirIn;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            if (wall || hit) begin
              state       <= S_DEAD;
              game_over_q <= 1'b1;
            end else begin
              cur_dir          <= eff_dir;
              head_x           <= nx;
              head_y           <= ny;
              head_ptr         <= next_ptr;
              body_x[next_ptr] <= nx;
              body_y[next_ptr] <= ny;
              ate_q            <= eat;
              if (grow) begin
                len_q <= len_q + CW'(1);
              end
            end
          end
          // A write in the tick cycle is held for the following tick.
          if (dirValid) begin
            pend_dir <= dirIn;
          end else if (tick) begin
            pend_dir <= eff_dir;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered segment query, one cycle after qIdx.
  always_ff @(posedge clk) begin
    if (reset) begin
      qx_q <= '0;
      qy_q <= '0;
      qv_q <= 1'b0;
    end else if ({1'b0, qIdx} < len_q) begin
      qx_q <= seg_x[qIdx[PW-1:0]];
      qy_q <= seg_y[qIdx[PW-1:0]];
      qv_q <= 1'b1;
    end else begin
      qx_q <= '0;
      qy_q <= '0;
      qv_q <= 1'b0;
    end
  end

  assign headX    = head_x;
  assign headY    = head_y;
  assign length   = len_q;
  assign ate      = ate_q;
  assign gameOver = game_over_q;
  assign qX       = qx_q;
  assign qY       = qy_q;
  assign qValid   = qv_q;

endmodule
